// File: rtl/data_cal_param_if.sv
// Handshake bundle between a packed-word producer, the calculator and its result consumer.
// Carries the input word (d/sel/mode) with in_valid/in_ready and the result with validout/out_ready.
// Optional out_par member exists only when DATA_CAL_PARITY_EN is defined.
interface data_cal_param_if #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
);
  localparam int SEL_W = $clog2(LANES);
  localparam int OUT_W = LANE_W + $clog2(LANES);

  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*LANE_W-1:0] d;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [OUT_W-1:0]        out;
  logic                    validout;
  logic                    out_ready;

`ifdef DATA_CAL_PARITY_EN
  logic                    out_par;

  modport master (
    output in_valid, d, sel, mode, out_ready,
    input  in_ready, out, validout, out_par
  );

  modport slave (
    input  in_valid, d, sel, mode, out_ready,
    output in_ready, out, validout, out_par
  );
`else
  modport master (
    output in_valid, d, sel, mode, out_ready,
    input  in_ready, out, validout
  );

  modport slave (
    input  in_valid, d, sel, mode, out_ready,
    output in_ready, out, validout
  );
`endif
endinterface

// File: rtl/data_cal_param.sv
// Lane calculator: PAIR mode adds lane0 + lane[sel]; SUM mode accumulates all lanes one per cycle.
// Latency: PAIR result registered at the accept edge; SUM result registered LANES edges after accept.
// Backpressure: one operation in flight; in_ready low from accept until the result is taken via out_ready.
// Optional feature macro: DATA_CAL_PARITY_EN adds out_par (XOR reduction of the loaded result).
module data_cal_param #(
  parameter int LANE_W = 4,
  parameter int LANES  = 4
) (
  input logic              clk,
  input logic              rst,
  data_cal_param_if.slave  bus
);
  localparam int SEL_W = $clog2(LANES);
  localparam int OUT_W = LANE_W + $clog2(LANES);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [LANES*LANE_W-1:0] cap_d;
  logic [OUT_W-1:0]        acc;
  logic [SEL_W-1:0]        idx;
  logic                    in_ready_q;
  logic                    validout_q;
  logic [OUT_W-1:0]        out_q;
  logic [OUT_W-1:0]        pair_sum;
  logic [OUT_W-1:0]        calc_sum;

  // Zero-extended lane fetch; an index past the last lane reads as zero.
  function automatic logic [OUT_W-1:0] lane_at(input logic [LANES*LANE_W-1:0] v,
                                              input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i == SEL_W'(k)) r = OUT_W'(v[k*LANE_W +: LANE_W]);
    end
    return r;
  endfunction

  // Candidate results: PAIR from the live input word, SUM step from the captured word.
  always_comb begin
    pair_sum = lane_at(bus.d, SEL_W'(0)) + lane_at(bus.d, bus.sel);
    calc_sum = acc + lane_at(cap_d, idx);
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_d      <= '0;
      acc        <= '0;
      idx        <= '0;
      in_ready_q <= 1'b1;
      validout_q <= 1'b0;
      out_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            cap_d      <= bus.d;
            in_ready_q <= 1'b0;
            if (!bus.mode) begin
              out_q      <= pair_sum;
              validout_q <= 1'b1;
              state      <= DONE;
            end else begin
              acc   <= '0;
              idx   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= calc_sum;
          idx <= idx + SEL_W'(1);
          if (idx == LAST_IDX) begin
            out_q      <= calc_sum;
            validout_q <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            validout_q <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b1;
          validout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.validout = validout_q;
  assign bus.out      = out_q;

`ifdef DATA_CAL_PARITY_EN
  logic out_par_q;

  // Parity loaded in the same cycles as out, so it is stable while DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par_q <= 1'b0;
    end else if (state == IDLE && bus.in_valid && !bus.mode) begin
      out_par_q <= ^pair_sum;
    end else if (state == CALC && idx == LAST_IDX) begin
      out_par_q <= ^calc_sum;
    end
  end

  assign bus.out_par = out_par_q;
`endif
endmodule
